// File: rtl/mult_div_seq.sv
// Sequential signed 32x32 multiplier (radix-2 Booth) and restoring divider.
// One iteration per RUN cycle; HI/LO results are registered and written on entry to DONE.
module mult_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        hilo_write,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;
    localparam int unsigned AW = 2 * W + 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [W-1:0]  ZERO     = '0;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          div_zero_nxt;
    logic          hilo_write_nxt;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          op_q;
    logic [AW-1:0] acc;
    logic [W-1:0]  m_q;
    logic [CW-1:0] cnt;
    logic          neg_q;
    logic          neg_r;

    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W:0]    booth_upper;
    logic [W:0]    booth_m;
    logic [W:0]    booth_sum;
    logic [AW-1:0] booth_nxt;
    logic [W:0]    div_shift;
    logic [W+1:0]  div_diff;
    logic          div_ge;
    logic [AW-1:0] div_nxt;
    logic [W-1:0]  quo;
    logic [W-1:0]  rem;
    logic [W-1:0]  fix_hi;
    logic [W-1:0]  fix_lo;

    // Operand magnitudes for the divider; 0x80000000 maps onto itself as unsigned.
    always_comb begin
        a_mag = a_q[W-1] ? (ZERO - a_q) : a_q;
        b_mag = b_q[W-1] ? (ZERO - b_q) : b_q;
    end

    // Booth step: add/sub in 33 bits so the most negative multiplicand cannot overflow.
    always_comb begin
        booth_upper = {acc[AW-1], acc[AW-1:W+1]};
        booth_m     = {m_q[W-1], m_q};
        booth_sum   = booth_upper;
        case (acc[1:0])
            2'b01:   booth_sum = booth_upper + booth_m;
            2'b10:   booth_sum = booth_upper - booth_m;
            default: booth_sum = booth_upper;
        endcase
        booth_nxt = {booth_sum, acc[W:1]};
    end

    // Restoring division step: remainder in acc[64:32], dividend/quotient in acc[31:0].
    always_comb begin
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, m_q};
        div_ge    = ~div_diff[W+1];
        div_nxt   = {(div_ge ? div_diff[W:0] : div_shift), acc[W-2:0], div_ge};
    end

    // Final result selection with divide sign correction.
    always_comb begin
        quo = acc[W-1:0];
        rem = acc[2*W-1:W];
        if (op_q) begin
            fix_lo = neg_q ? (ZERO - quo) : quo;
            fix_hi = neg_r ? (ZERO - rem) : rem;
        end else begin
            fix_lo = acc[W:1];
            fix_hi = acc[AW-1:W+1];
        end
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            hilo_write <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            div_zero   <= div_zero_nxt;
            hilo_write <= hilo_write_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt      = state;
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;
        div_zero_nxt   = 1'b0;
        hilo_write_nxt = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = (op_q && (b_q == ZERO)) ? ST_DONE : ST_RUN;
            ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt       = (state_nxt != ST_IDLE);
        done_nxt       = (state_nxt == ST_DONE);
        div_zero_nxt   = (state_nxt == ST_DONE) && (state == ST_LOAD);
        hilo_write_nxt = (state_nxt == ST_DONE) && (state == ST_FIX);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 1'b0;
            acc   <= '0;
            m_q   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q  <= a_in;
                        b_q  <= b_in;
                        op_q <= op;
                    end
                end
                ST_LOAD: begin
                    cnt <= '0;
                    if (op_q) begin
                        acc   <= {{(W+1){1'b0}}, a_mag};
                        m_q   <= b_mag;
                        neg_q <= a_q[W-1] ^ b_q[W-1];
                        neg_r <= a_q[W-1];
                    end else begin
                        acc   <= {ZERO, b_q, 1'b0};
                        m_q   <= a_q;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc <= op_q ? div_nxt : booth_nxt;
                    if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
                end
                ST_FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed + random bench for mult_div_seq with a result scoreboard and latency checks.
module tb_mult_div_seq;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        hilo_write;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hilo_write(hilo_write),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model built on the simulator's 64-bit signed arithmetic.
    task automatic push_expected(input logic o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb_, p, q, r;
        logic [63:0] pv;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        if (o && b == 32'd0) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.dz = 1'b1;
        end else if (o) begin
            q = sa / sb_;
            r = sa % sb_;
            e.lo = q[31:0];
            e.hi = r[31:0];
            e.dz = 1'b0;
        end else begin
            p = sa * sb_;
            pv = p;
            e.hi = pv[63:32];
            e.lo = pv[31:0];
            e.dz = 1'b0;
        end
        m_hi = e.hi;
        m_lo = e.lo;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input bit start_in_done);
        int j;
        int exp_lat;
        bit busy_ok;
        exp_t e;
        push_expected(o, a, b);
        exp_lat = (o && b == 32'd0) ? 2 : 35;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        a_in  = $urandom;
        b_in  = $urandom;
        check("busy_k1", {63'd0, busy}, 64'd1);
        j = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && j < 40) begin
            @(posedge clk);
            #1;
            j++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        check("latency", 64'(j), 64'(exp_lat));
        check("busy_window", {63'd0, busy_ok}, 64'd1);
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                check("hi", {32'd0, hi}, {32'd0, e.hi});
                check("lo", {32'd0, lo}, {32'd0, e.lo});
                check("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
                check("hilo_write", {63'd0, hilo_write}, {63'd0, ~e.dz});
            end
        end
        if (start_in_done) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("idle_after_done_busy", {63'd0, busy}, 64'd0);
        check("idle_after_done_done", {63'd0, done}, 64'd0);
    endtask

    initial begin
        bit saw_done;
        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #12;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_flags", {62'd0, div_zero, hilo_write}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(1'b1, 32'd5, 32'd0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        run_op(1'b1, 32'd3, 32'd10, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(i[0], $urandom, $urandom, 1'b0);
        end

        // Abort mid-RUN: second start must be ignored, reset must clear everything.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a_in  = 32'd123;
        b_in  = 32'd456;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 1'b1;
        a_in  = 32'd99;
        b_in  = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("abort_busy_k11", {63'd0, busy}, 64'd1);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_flags", {62'd0, div_zero, hilo_write}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || hilo_write === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", {63'd0, saw_done}, 64'd0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd9, 1'b0);
        run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have a port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have a port start, input, 1 bit: operation request from the main controller, sampled only in IDLE.
REQ-004 The block SHALL have a port op, input, 1 bit: 0 selects mult, 1 selects div; sampled with start.
REQ-005 The block SHALL have a port a_in, input, 32 bits: rs operand (multiplicand or dividend), two's complement.
REQ-006 The block SHALL have a port b_in, input, 32 bits: rt operand (multiplier or divisor), two's complement.
REQ-007 The block SHALL have a port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have a port done, output, 1 bit: one-cycle pulse marking operation end.
REQ-009 The block SHALL have a port div_zero, output, 1 bit: one-cycle pulse, coincident with done, on a divide by zero.
REQ-010 The block SHALL have a port hilo_write, output, 1 bit: one-cycle pulse, coincident with done, when hi/lo hold a new valid result.
REQ-011 The block SHALL have a port hi, output, 32 bits: registered HI result.
REQ-012 The block SHALL have a port lo, output, 32 bits: registered LO result.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, RUN, FIX and DONE; all outputs SHALL be registered or decoded from state only.
REQ-014 In IDLE, start=1 at edge k SHALL latch a_in, b_in and op and enter LOAD at k+1; start=0 SHALL keep the FSM in IDLE.
REQ-015 start SHALL be ignored in every state except IDLE; a_in, b_in and op changes after edge k SHALL have no effect.
REQ-016 In LOAD, on div with latched b=0, the FSM SHALL go to DONE, skipping RUN and FIX.
REQ-017 In all other LOAD cases the FSM SHALL go to RUN with a 5-bit iteration counter cleared to 0.
REQ-018 RUN SHALL last exactly 32 cycles (counter 0..31), then go to FIX; the counter SHALL not wrap into a 33rd iteration.
REQ-019 mult SHALL use radix-2 Booth, one step per RUN cycle, on a 65-bit accumulator, with arithmetic right shift.
REQ-020 div SHALL use restoring division on magnitudes, one quotient bit per RUN cycle, with a 33-bit partial remainder.
REQ-021 FIX SHALL apply the sign correction for div: the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign.
REQ-022 FIX SHALL pass the mult result through unchanged.
REQ-023 For mult, {hi,lo} SHALL equal the exact signed 64-bit product.
REQ-024 For div, lo SHALL be the quotient truncated toward zero and hi SHALL be the remainder.
REQ-025 Dividing 0x80000000 by 0xFFFFFFFF SHALL wrap to lo=0x80000000, hi=0x00000000, with no exception.
REQ-026 hi and lo SHALL update only on the edge entering DONE on a valid (non-zero-divisor) result, and SHALL otherwise hold.
REQ-027 In DONE the block SHALL assert done=1, with hilo_write=1 for a valid result, or div_zero=1 and hilo_write=0 for a zero divisor.
REQ-028 From DONE the FSM SHALL return to IDLE unconditionally on the next edge.
REQ-029 Latency: done SHALL be high during cycle k+35 for normal operations and k+2 for a zero divisor.
REQ-030 A start in cycle k+35 itself SHALL be ignored; a new start is accepted from k+36 on.

Reset
REQ-031 reset=0 SHALL force IDLE immediately, asynchronously, from any state including mid-RUN.
REQ-032 On reset, busy, done, div_zero, hilo_write=0, hi=lo=0x00000000, the counter=0 and all internal registers SHALL clear.
REQ-033 An aborted operation SHALL never produce done or hilo_write.
REQ-034 After reset deasserts, the first rising edge SHALL sample start normally in IDLE.

Verification
REQ-035 mult a=7, b=0xFFFFFFFD -> at k+35: done=1, hilo_write=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high k+1..k+35.
REQ-036 mult a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-037 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001.
REQ-038 div a=5, b=0 with hi/lo preloaded by a prior op -> at k+2: done=1, div_zero=1, hilo_write=0, hi/lo unchanged.
REQ-039 div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-040 Start at k, pulse start again at k+10 with new operands, assert reset=0 at k+20 -> the k+10 start is ignored, the FSM returns to IDLE, all outputs are 0, and there is no done pulse; a fresh op afterwards yields the correct result.
